// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared definitions for the multi-cycle execute stage:
//   - ALU control encodings, including the HI/LO and multiply/divide ops
//   - iterative-unit FSM state type
//   - operand forwarding select codes
//   - is_muldiv() helper used to spot iterative ops
// ---------------------------------------------------------------------------
package exe_pkg;

   // Single-cycle ALU operations
   localparam logic [5:0] ALU_ADD   = 6'h00;
   localparam logic [5:0] ALU_SUB   = 6'h01;
   localparam logic [5:0] ALU_AND   = 6'h02;
   localparam logic [5:0] ALU_OR    = 6'h03;
   localparam logic [5:0] ALU_XOR   = 6'h04;
   localparam logic [5:0] ALU_NOR   = 6'h05;
   localparam logic [5:0] ALU_SLT   = 6'h06;
   localparam logic [5:0] ALU_SLTU  = 6'h07;
   localparam logic [5:0] ALU_SLL   = 6'h08;
   localparam logic [5:0] ALU_SRL   = 6'h09;
   localparam logic [5:0] ALU_SRA   = 6'h0A;
   localparam logic [5:0] ALU_LUI   = 6'h0B;

   // Iterative and HI/LO operations
   localparam logic [5:0] ALU_MULT  = 6'h10;
   localparam logic [5:0] ALU_MULTU = 6'h11;
   localparam logic [5:0] ALU_DIV   = 6'h12;
   localparam logic [5:0] ALU_DIVU  = 6'h13;
   localparam logic [5:0] ALU_MFHI  = 6'h14;
   localparam logic [5:0] ALU_MFLO  = 6'h15;
   localparam logic [5:0] ALU_MTHI  = 6'h16;
   localparam logic [5:0] ALU_MTLO  = 6'h17;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } md_state_t;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_MEM = 2'd1;
   localparam logic [1:0] FWD_WB  = 2'd2;

   function automatic logic is_muldiv(input logic [5:0] ctl);
      return ctl inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// One-bit-per-cycle multiply (shift-add) / divide (restoring) on operand
// magnitudes, with sign fixup on the way out.
// Ports:
//   CLK, RESET        clock, asynchronous active-low reset
//   start             accept a, b, is_signed and op (0 = multiply, 1 = divide)
//   is_signed, op     operation mode, sampled on start
//   a, b              operands (multiplicand/multiplier or dividend/divisor)
//   stall_in          downstream cannot take the result this cycle
//   busy              unit is not idle
//   done              result retires this cycle (hi/lo valid)
//   hi, lo            product high/low, or remainder/quotient
// ---------------------------------------------------------------------------
module muldiv_iter
   import exe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            start,
   input  logic            is_signed,
   input  logic            op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            stall_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int CW = $clog2(XLEN);

   md_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [2*XLEN-1:0] acc_q, acc_step, res, prod;
   logic [XLEN-1:0]   dsr_q, a_raw_q, quo, rem;
   logic [XLEN:0]     add_sum, cand, diff;
   logic              div_q, a_neg_q, b_neg_q, b_zero_q, last_iter;
   logic              a_neg, b_neg;

   function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign a_neg = is_signed & a[XLEN-1];
   assign b_neg = is_signed & b[XLEN-1];

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
      cand    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff    = cand - {1'b0, dsr_q};
      if (!div_q)
         acc_step = {add_sum, acc_q[XLEN-1:1]};
      else if (!diff[XLEN])
         acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_step = {cand[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   // On the last iteration the final value is still combinational
   always_comb begin
      res  = (state_q == ST_DONE) ? acc_q : acc_step;
      prod = (a_neg_q ^ b_neg_q) ? -res : res;
      quo  = res[XLEN-1:0];
      rem  = res[2*XLEN-1:XLEN];
      hi   = prod[2*XLEN-1:XLEN];
      lo   = prod[XLEN-1:0];
      if (div_q) begin
         if (b_zero_q) begin
            hi = a_raw_q;
            lo = '1;
         end else begin
            lo = (a_neg_q ^ b_neg_q) ? -quo : quo;
            hi = a_neg_q ? -rem : rem;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      done      = 1'b0;
      last_iter = (state_q == ST_BUSY) && (cnt_q == CW'(XLEN - 1));
      case (state_q)
         ST_IDLE: if (start) state_d = ST_BUSY;
         ST_BUSY: begin
            if (last_iter) begin
               if (!stall_in) begin
                  done    = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (!stall_in) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         dsr_q    <= '0;
         a_raw_q  <= '0;
         div_q    <= 1'b0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         b_zero_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE && start) begin
            cnt_q    <= '0;
            div_q    <= op;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_zero_q <= (b == '0);
            a_raw_q  <= a;
            acc_q    <= {{XLEN{1'b0}}, op ? mag(a, a_neg) : mag(b, b_neg)};
            dsr_q    <= op ? mag(b, b_neg) : mag(a, a_neg);
         end else if (state_q == ST_BUSY) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/exe_stage_mc.sv
// ---------------------------------------------------------------------------
// exe_stage_mc
// Multi-cycle execute stage between ID/EXE and EXE/MEM: MEM/WB operand
// forwarding, single-cycle ALU, HI/LO registers fed by an iterative
// multiply/divide unit, and stall handshakes towards ID and from MEM.
// Ports:
//   CLK, RESET                       clock, asynchronous active-low reset
//   Valid_IN, Instr_IN, Instr_PC_IN  incoming instruction and debug info
//   OperandA_IN/B_IN, SrcA/B_Reg_IN  register-file operands and their indices
//   WriteRegister_IN, RegWrite_IN, MemRead_IN, MemWrite_IN, MemWriteData_IN
//                                    control/data passed on to MEM
//   ALU_Control_IN, ShiftAmount_IN   operation select and shift amount
//   MemWriteReg/MemRegWrite/Mem_ALU_result  MEM-stage forwarding source
//   WBWriteReg/WBRegWrite/WB_result         WB-stage forwarding source
//   Stall_IN                         MEM cannot accept; hold outputs
//   Stall_OUT                        ID must hold its instruction
//   *_OUT                            registered outputs to MEM
// ---------------------------------------------------------------------------
module exe_stage_mc
   import exe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CTLW = 6
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            Valid_IN,
   input  logic [XLEN-1:0] Instr_IN,
   input  logic [XLEN-1:0] Instr_PC_IN,
   input  logic [XLEN-1:0] OperandA_IN,
   input  logic [XLEN-1:0] OperandB_IN,
   input  logic [REGW-1:0] SrcA_Reg_IN,
   input  logic [REGW-1:0] SrcB_Reg_IN,
   input  logic [REGW-1:0] WriteRegister_IN,
   input  logic            RegWrite_IN,
   input  logic            MemRead_IN,
   input  logic            MemWrite_IN,
   input  logic [XLEN-1:0] MemWriteData_IN,
   input  logic [CTLW-1:0] ALU_Control_IN,
   input  logic [4:0]      ShiftAmount_IN,
   input  logic [REGW-1:0] MemWriteReg,
   input  logic            MemRegWrite,
   input  logic [XLEN-1:0] Mem_ALU_result,
   input  logic [REGW-1:0] WBWriteReg,
   input  logic            WBRegWrite,
   input  logic [XLEN-1:0] WB_result,
   input  logic            Stall_IN,
   output logic            Stall_OUT,
   output logic            Valid_OUT,
   output logic [XLEN-1:0] Instr_OUT,
   output logic [XLEN-1:0] Instr_PC_OUT,
   output logic [XLEN-1:0] ALU_result_OUT,
   output logic [REGW-1:0] WriteRegister_OUT,
   output logic [XLEN-1:0] MemWriteData_OUT,
   output logic            RegWrite_OUT,
   output logic [CTLW-1:0] ALU_Control_OUT,
   output logic            MemRead_OUT,
   output logic            MemWrite_OUT
);

   logic [1:0]             sel_a, sel_b;
   logic [XLEN-1:0]        opa_p0, opb_p0, alu_p0, result_p0, stdata_p0;
   logic signed [XLEN-1:0] opa_s_p0, opb_s_p0;
   logic [XLEN-1:0]        hi_q, lo_q, md_hi, md_lo;
   logic [5:0]             op_p0;
   logic                   is_md, md_start, md_busy, md_done, int_stall, vld_p0;

   // Register 0 is hard-wired, so it is never a forwarding match
   function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src,
                                          input logic mem_we, input logic [REGW-1:0] mem_reg,
                                          input logic wb_we,  input logic [REGW-1:0] wb_reg);
      if (src == '0)                    return FWD_RF;
      if (mem_we && (mem_reg == src))   return FWD_MEM;
      if (wb_we && (wb_reg == src))     return FWD_WB;
      return FWD_RF;
   endfunction

   function automatic logic [XLEN-1:0] fwd_val(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] mem, input logic [XLEN-1:0] wb);
      case (sel)
         FWD_MEM: return mem;
         FWD_WB:  return wb;
         default: return rf;
      endcase
   endfunction

   assign sel_a     = fwd_sel(SrcA_Reg_IN, MemRegWrite, MemWriteReg, WBRegWrite, WBWriteReg);
   assign sel_b     = fwd_sel(SrcB_Reg_IN, MemRegWrite, MemWriteReg, WBRegWrite, WBWriteReg);
   assign opa_p0    = fwd_val(sel_a, OperandA_IN, Mem_ALU_result, WB_result);
   assign opb_p0    = fwd_val(sel_b, OperandB_IN, Mem_ALU_result, WB_result);
   assign stdata_p0 = (sel_b == FWD_RF) ? MemWriteData_IN : opb_p0;
   assign opa_s_p0  = opa_p0;
   assign opb_s_p0  = opb_p0;
   assign op_p0     = 6'(ALU_Control_IN);

   always_comb begin
      alu_p0 = '0;
      case (op_p0)
         ALU_ADD:  alu_p0 = opa_p0 + opb_p0;
         ALU_SUB:  alu_p0 = opa_p0 - opb_p0;
         ALU_AND:  alu_p0 = opa_p0 & opb_p0;
         ALU_OR:   alu_p0 = opa_p0 | opb_p0;
         ALU_XOR:  alu_p0 = opa_p0 ^ opb_p0;
         ALU_NOR:  alu_p0 = ~(opa_p0 | opb_p0);
         ALU_SLT:  alu_p0 = XLEN'(opa_s_p0 < opb_s_p0);
         ALU_SLTU: alu_p0 = XLEN'(opa_p0 < opb_p0);
         ALU_SLL:  alu_p0 = opb_p0 << ShiftAmount_IN;
         ALU_SRL:  alu_p0 = opb_p0 >> ShiftAmount_IN;
         ALU_SRA:  alu_p0 = opb_s_p0 >>> ShiftAmount_IN;
         ALU_LUI:  alu_p0 = opb_p0 << (XLEN / 2);
         ALU_MFHI: alu_p0 = hi_q;
         ALU_MFLO: alu_p0 = lo_q;
         default:  alu_p0 = '0;
      endcase
   end

   // ID keeps presenting the mult/div while Stall_OUT is high, so the
   // same instruction is on the inputs again when the unit completes.
   assign is_md     = Valid_IN && is_muldiv(op_p0);
   assign md_start  = is_md && !md_busy && !Stall_IN;
   assign int_stall = md_start || (md_busy && !md_done);
   assign Stall_OUT = Stall_IN || int_stall;
   assign vld_p0    = Valid_IN && !int_stall;
   assign result_p0 = md_done ? md_lo : alu_p0;

   muldiv_iter #(.XLEN(XLEN)) u_md (
      .CLK       (CLK),
      .RESET     (RESET),
      .start     (md_start),
      .is_signed (op_p0 == ALU_MULT || op_p0 == ALU_DIV),
      .op        (op_p0 == ALU_DIV || op_p0 == ALU_DIVU),
      .a         (opa_p0),
      .b         (opb_p0),
      .stall_in  (Stall_IN),
      .busy      (md_busy),
      .done      (md_done),
      .hi        (md_hi),
      .lo        (md_lo)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (!Stall_IN) begin
         if (md_done) begin
            hi_q <= md_hi;
            lo_q <= md_lo;
         end else if (vld_p0 && op_p0 == ALU_MTHI) begin
            hi_q <= opa_p0;
         end else if (vld_p0 && op_p0 == ALU_MTLO) begin
            lo_q <= opa_p0;
         end
      end
   end

   // EXE/MEM boundary: bubbles mask only the control bits
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Valid_OUT         <= 1'b0;
         Instr_OUT         <= '0;
         Instr_PC_OUT      <= '0;
         ALU_result_OUT    <= '0;
         WriteRegister_OUT <= '0;
         MemWriteData_OUT  <= '0;
         RegWrite_OUT      <= 1'b0;
         ALU_Control_OUT   <= '0;
         MemRead_OUT       <= 1'b0;
         MemWrite_OUT      <= 1'b0;
      end else if (!Stall_IN) begin
         Valid_OUT         <= vld_p0;
         Instr_OUT         <= Instr_IN;
         Instr_PC_OUT      <= Instr_PC_IN;
         ALU_result_OUT    <= result_p0;
         WriteRegister_OUT <= WriteRegister_IN;
         MemWriteData_OUT  <= stdata_p0;
         RegWrite_OUT      <= vld_p0 && RegWrite_IN;
         ALU_Control_OUT   <= ALU_Control_IN;
         MemRead_OUT       <= vld_p0 && MemRead_IN;
         MemWrite_OUT      <= vld_p0 && MemWrite_IN;
      end
   end

endmodule

// File: tb/tb_exe_stage_mc.sv
module tb_exe_stage_mc;
   import exe_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        Valid_IN;
   logic [31:0] Instr_IN, Instr_PC_IN, OperandA_IN, OperandB_IN, MemWriteData_IN;
   logic [4:0]  SrcA_Reg_IN, SrcB_Reg_IN, WriteRegister_IN, MemWriteReg, WBWriteReg;
   logic        RegWrite_IN, MemRead_IN, MemWrite_IN, MemRegWrite, WBRegWrite, Stall_IN;
   logic [5:0]  ALU_Control_IN;
   logic [4:0]  ShiftAmount_IN;
   logic [31:0] Mem_ALU_result, WB_result;
   logic        Stall_OUT, Valid_OUT, RegWrite_OUT, MemRead_OUT, MemWrite_OUT;
   logic [31:0] Instr_OUT, Instr_PC_OUT, ALU_result_OUT, MemWriteData_OUT;
   logic [4:0]  WriteRegister_OUT;
   logic [5:0]  ALU_Control_OUT;

   int n_checks = 0;
   int n_fail   = 0;

   exe_stage_mc #(.XLEN(32), .REGW(5), .CTLW(6)) dut (
      .CLK(CLK), .RESET(RESET), .Valid_IN(Valid_IN), .Instr_IN(Instr_IN),
      .Instr_PC_IN(Instr_PC_IN), .OperandA_IN(OperandA_IN), .OperandB_IN(OperandB_IN),
      .SrcA_Reg_IN(SrcA_Reg_IN), .SrcB_Reg_IN(SrcB_Reg_IN),
      .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN),
      .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .MemWriteData_IN(MemWriteData_IN),
      .ALU_Control_IN(ALU_Control_IN), .ShiftAmount_IN(ShiftAmount_IN),
      .MemWriteReg(MemWriteReg), .MemRegWrite(MemRegWrite), .Mem_ALU_result(Mem_ALU_result),
      .WBWriteReg(WBWriteReg), .WBRegWrite(WBRegWrite), .WB_result(WB_result),
      .Stall_IN(Stall_IN), .Stall_OUT(Stall_OUT), .Valid_OUT(Valid_OUT),
      .Instr_OUT(Instr_OUT), .Instr_PC_OUT(Instr_PC_OUT), .ALU_result_OUT(ALU_result_OUT),
      .WriteRegister_OUT(WriteRegister_OUT), .MemWriteData_OUT(MemWriteData_OUT),
      .RegWrite_OUT(RegWrite_OUT), .ALU_Control_OUT(ALU_Control_OUT),
      .MemRead_OUT(MemRead_OUT), .MemWrite_OUT(MemWrite_OUT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic clear_inputs();
      Valid_IN = 0; Instr_IN = 0; Instr_PC_IN = 0; OperandA_IN = 0; OperandB_IN = 0;
      MemWriteData_IN = 0; SrcA_Reg_IN = 0; SrcB_Reg_IN = 0; WriteRegister_IN = 0;
      MemWriteReg = 0; WBWriteReg = 0; RegWrite_IN = 0; MemRead_IN = 0; MemWrite_IN = 0;
      MemRegWrite = 0; WBRegWrite = 0; Stall_IN = 0; ALU_Control_IN = 0; ShiftAmount_IN = 0;
      Mem_ALU_result = 0; WB_result = 0;
   endtask

   task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      Valid_IN = 1; ALU_Control_IN = op; OperandA_IN = a; OperandB_IN = b;
      SrcA_Reg_IN = 0; SrcB_Reg_IN = 0;
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   // Holds the current mult/div inputs until Stall_OUT drops, then returns just
   // after the retiring edge with Valid_IN already deasserted.
   task automatic run_md(output int stalls, output bit timed_out);
      logic s;
      stalls = 0; timed_out = 1;
      for (int i = 0; i < 100; i++) begin
         #1; s = Stall_OUT;
         @(posedge CLK); #1;
         if (!s) begin timed_out = 0; break; end
         stalls++;
      end
      Valid_IN = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      RESET = 0;
      #2;
      n_checks++; if (Valid_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", Valid_OUT); end
      n_checks++; if (ALU_result_OUT !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", ALU_result_OUT); end
      n_checks++; if (Stall_OUT !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", Stall_OUT); end
      n_checks++; if (dut.hi_q !== 32'h0 || dut.lo_q !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", dut.hi_q, dut.lo_q); end
      #6 RESET = 1;
      tick();
   endtask

   task automatic test_forwarding();
      clear_inputs();
      set_op(ALU_ADD, 32'h5, 32'h1);
      SrcA_Reg_IN = 3; MemRegWrite = 1; MemWriteReg = 3; Mem_ALU_result = 32'h11;
      WBRegWrite = 1; WBWriteReg = 3; WB_result = 32'h22;
      RegWrite_IN = 1; WriteRegister_IN = 7; Instr_IN = 32'h1234;
      #1;
      n_checks++; if (Stall_OUT !== 1'b0) begin n_fail++; $display("FAIL fwd_stall: got %b want 0", Stall_OUT); end
      tick();
      n_checks++; if (ALU_result_OUT !== 32'h12) begin n_fail++; $display("FAIL fwd_mem_wins: got %h want 12", ALU_result_OUT); end
      n_checks++; if (Valid_OUT !== 1'b1 || RegWrite_OUT !== 1'b1) begin n_fail++; $display("FAIL fwd_valid: got %b%b want 11", Valid_OUT, RegWrite_OUT); end
      n_checks++; if (WriteRegister_OUT !== 5'd7 || Instr_OUT !== 32'h1234) begin n_fail++; $display("FAIL fwd_passthru: got %0d/%h want 7/1234", WriteRegister_OUT, Instr_OUT); end
      MemRegWrite = 0;
      tick();
      n_checks++; if (ALU_result_OUT !== 32'h23) begin n_fail++; $display("FAIL fwd_wb: got %h want 23", ALU_result_OUT); end
      MemRegWrite = 1; SrcA_Reg_IN = 0; MemWriteReg = 0; WBWriteReg = 0;
      tick();
      n_checks++; if (ALU_result_OUT !== 32'h6) begin n_fail++; $display("FAIL fwd_r0: got %h want 6", ALU_result_OUT); end
      SrcB_Reg_IN = 4; MemWriteReg = 4; Mem_ALU_result = 32'h44; WBWriteReg = 4; WB_result = 32'h55;
      MemWriteData_IN = 32'h99; MemWrite_IN = 1;
      tick();
      n_checks++; if (ALU_result_OUT !== 32'h49) begin n_fail++; $display("FAIL fwd_b_mem: got %h want 49", ALU_result_OUT); end
      n_checks++; if (MemWriteData_OUT !== 32'h44 || MemWrite_OUT !== 1'b1) begin n_fail++; $display("FAIL fwd_store_mem: got %h/%b want 44/1", MemWriteData_OUT, MemWrite_OUT); end
      MemRegWrite = 0;
      tick();
      n_checks++; if (ALU_result_OUT !== 32'h5A || MemWriteData_OUT !== 32'h55) begin n_fail++; $display("FAIL fwd_b_wb: got %h/%h want 5a/55", ALU_result_OUT, MemWriteData_OUT); end
      SrcB_Reg_IN = 9;
      tick();
      n_checks++; if (ALU_result_OUT !== 32'h6 || MemWriteData_OUT !== 32'h99) begin n_fail++; $display("FAIL fwd_none_b: got %h/%h want 6/99", ALU_result_OUT, MemWriteData_OUT); end
      clear_inputs();
   endtask

   task automatic test_alu();
      logic [5:0]  ops[8];
      logic [31:0] av[8], bv[8], ev[8];
      logic [4:0]  sv[8];
      ops = '{ALU_SUB, ALU_SLT, ALU_SLTU, ALU_SRA, ALU_SRL, ALU_SLL, ALU_NOR, ALU_LUI};
      av  = '{32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      bv  = '{32'h7, 32'h1, 32'h1, 32'h80000000, 32'h80000000, 32'h1, 32'hF0F0F0F0, 32'h1234};
      sv  = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd31, 5'd0, 5'd0};
      ev  = '{32'hFFFFFFFE, 32'h1, 32'h0, 32'hF8000000, 32'h08000000, 32'h80000000, 32'h0F0F0F0F, 32'h12340000};
      clear_inputs();
      for (int i = 0; i < 8; i++) begin
         set_op(ops[i], av[i], bv[i]);
         ShiftAmount_IN = sv[i];
         tick();
         n_checks++; if (ALU_result_OUT !== ev[i]) begin n_fail++; $display("FAIL alu_op%0h: got %h want %h", ops[i], ALU_result_OUT, ev[i]); end
      end
      clear_inputs();
   endtask

   task automatic test_hilo_moves();
      clear_inputs();
      set_op(ALU_MTHI, 32'hCAFE0001, 0); tick();
      set_op(ALU_MTLO, 32'h0BAD0002, 0); tick();
      set_op(ALU_MFHI, 0, 0); tick();
      n_checks++; if (ALU_result_OUT !== 32'hCAFE0001) begin n_fail++; $display("FAIL mthi_mfhi: got %h want cafe0001", ALU_result_OUT); end
      set_op(ALU_MFLO, 0, 0); tick();
      n_checks++; if (ALU_result_OUT !== 32'h0BAD0002) begin n_fail++; $display("FAIL mtlo_mflo: got %h want 0bad0002", ALU_result_OUT); end
      clear_inputs();
   endtask

   task automatic test_multu();
      int stalls; bit to;
      clear_inputs();
      set_op(ALU_MULTU, 32'hFFFFFFFF, 32'h2);
      run_md(stalls, to);
      n_checks++; if (to || stalls !== 32) begin n_fail++; $display("FAIL multu_stall_cycles: got %0d (timeout %0b) want 32", stalls, to); end
      n_checks++; if (Valid_OUT !== 1'b1 || ALU_result_OUT !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_retire: got %b/%h want 1/fffffffe", Valid_OUT, ALU_result_OUT); end
      set_op(ALU_MFLO, 0, 0); tick();
      n_checks++; if (ALU_result_OUT !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_mflo: got %h want fffffffe", ALU_result_OUT); end
      set_op(ALU_MFHI, 0, 0); tick();
      n_checks++; if (ALU_result_OUT !== 32'h1) begin n_fail++; $display("FAIL multu_mfhi: got %h want 1", ALU_result_OUT); end
      clear_inputs();
   endtask

   task automatic test_div();
      int stalls; bit to;
      clear_inputs();
      set_op(ALU_DIV, 32'hFFFFFFF9, 32'h2);
      run_md(stalls, to);
      n_checks++; if (to || stalls !== 32) begin n_fail++; $display("FAIL div_stall_cycles: got %0d (timeout %0b) want 32", stalls, to); end
      n_checks++; if (ALU_result_OUT !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_quotient: got %h want fffffffd", ALU_result_OUT); end
      set_op(ALU_MFHI, 0, 0); tick();
      n_checks++; if (ALU_result_OUT !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_remainder: got %h want ffffffff", ALU_result_OUT); end
      set_op(ALU_DIVU, 32'h5, 32'h0);
      run_md(stalls, to);
      n_checks++; if (to || ALU_result_OUT !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_lo: got %h (timeout %0b) want ffffffff", ALU_result_OUT, to); end
      set_op(ALU_MFHI, 0, 0); tick();
      n_checks++; if (ALU_result_OUT !== 32'h5) begin n_fail++; $display("FAIL divu0_hi: got %h want 5", ALU_result_OUT); end
      clear_inputs();
   endtask

   // HI=5, LO=ffffffff on entry (left by the DIVU 5/0 above)
   task automatic test_stall_done();
      int vcount = 0; int smis = 0;
      clear_inputs();
      set_op(ALU_MULTU, 32'd6, 32'd7);
      for (int c = 0; c < 36; c++) begin
         Stall_IN = (c >= 32 && c <= 34);
         #1;
         if (Stall_OUT !== 1'(c <= 34)) smis++;
         @(posedge CLK); #1;
         if (Valid_OUT === 1'b1) vcount++;
         if (c == 33) begin
            n_checks++; if (dut.u_md.state_q !== ST_DONE) begin n_fail++; $display("FAIL stall_state_done: got %0d want %0d", dut.u_md.state_q, ST_DONE); end
            n_checks++; if (dut.hi_q !== 32'h5 || dut.lo_q !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL stall_hilo_held: got %h/%h want 5/ffffffff", dut.hi_q, dut.lo_q); end
         end
      end
      Stall_IN = 0; Valid_IN = 0;
      n_checks++; if (smis !== 0) begin n_fail++; $display("FAIL stall_out_profile: got %0d wrong cycles want 0", smis); end
      n_checks++; if (vcount !== 1 || Valid_OUT !== 1'b1) begin n_fail++; $display("FAIL stall_retire_once: got %0d valids (last %b) want 1", vcount, Valid_OUT); end
      n_checks++; if (ALU_result_OUT !== 32'd42 || dut.hi_q !== 32'h0) begin n_fail++; $display("FAIL stall_result: got %h/%h want 2a/0", ALU_result_OUT, dut.hi_q); end
      clear_inputs();
   endtask

   task automatic test_reset_mid_div();
      int stalls; bit to;
      clear_inputs();
      set_op(ALU_DIV, 32'd100, 32'd7);
      Instr_IN = 32'hDEADBEEF; RegWrite_IN = 1;
      for (int c = 0; c < 10; c++) tick();
      #2 RESET = 0;
      #1;
      n_checks++; if (Valid_OUT !== 1'b0 || Instr_OUT !== 32'h0 || ALU_result_OUT !== 32'h0 || RegWrite_OUT !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b/%h/%h/%b want 0/0/0/0", Valid_OUT, Instr_OUT, ALU_result_OUT, RegWrite_OUT); end
      n_checks++; if (dut.hi_q !== 32'h0 || dut.lo_q !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", dut.hi_q, dut.lo_q); end
      n_checks++; if (dut.u_md.state_q !== ST_IDLE || dut.u_md.cnt_q !== 5'd0) begin n_fail++; $display("FAIL rst_mid_fsm: got %0d/%0d want 0/0", dut.u_md.state_q, dut.u_md.cnt_q); end
      clear_inputs();
      tick();
      RESET = 1;
      set_op(ALU_MULT, 32'hFFFFFFFD, 32'd5);
      run_md(stalls, to);
      n_checks++; if (to || stalls !== 32 || ALU_result_OUT !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL rst_then_mult_lo: got %h after %0d stalls want fffffff1 after 32", ALU_result_OUT, stalls); end
      set_op(ALU_MFHI, 0, 0); tick();
      n_checks++; if (ALU_result_OUT !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rst_then_mult_hi: got %h want ffffffff", ALU_result_OUT); end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic [31:0] v[4];
      logic        gap;
      v = '{32'd1, 32'd2, 32'd0, 32'd3};
      clear_inputs();
      for (int i = 0; i < 4; i++) begin
         gap = (i == 2);
         set_op(ALU_ADD, v[i], v[i]);
         RegWrite_IN = 1; WriteRegister_IN = 5'd2;
         if (gap) Valid_IN = 0;
         #1;
         n_checks++; if (Stall_OUT !== 1'b0) begin n_fail++; $display("FAIL b2b_stall%0d: got %b want 0", i, Stall_OUT); end
         @(posedge CLK); #1;
         n_checks++; if (Valid_OUT !== !gap || RegWrite_OUT !== !gap) begin n_fail++; $display("FAIL b2b_valid%0d: got %b/%b want %b", i, Valid_OUT, RegWrite_OUT, !gap); end
         if (!gap) begin
            n_checks++; if (ALU_result_OUT !== 2 * v[i]) begin n_fail++; $display("FAIL b2b_result%0d: got %h want %h", i, ALU_result_OUT, 2 * v[i]); end
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_alu();
      test_hilo_moves();
      test_multu();
      test_div();
      test_stall_done();
      test_reset_mid_div();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
